shift_entry_reg: RTL and testbench
==================================

Name: shift_entry_reg

Overview:
Parametrised successor to the pushbutton-driven operand shift register. It edge-detects raw bit-entry and commit buttons and shifts entered bits into a WIDTH-bit operand in either direction. It also supports rotate, arithmetic-right and parallel-load modes, and tracks the entered-bit count. A committed operand is handed to the ALU datapath over a valid/ready handshake; the live value drives the seven-segment decoders.

Parameters:
WIDTH, 8, operand width in bits (>= 2).
AUTO_CLEAR, 1, 1 = clear value and count when an output handshake completes; 0 = keep them.

Ports:
hz100  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn0  input  1  raw level, bit-0 entry button
btn1  input  1  raw level, bit-1 entry button
btn_commit  input  1  raw level, commit button
dir  input  1  0 = shift/rotate toward MSB (insert at LSB); 1 = toward LSB (insert at MSB)
mode  input  2  00 shift-in, 01 rotate, 10 arithmetic (sign-preserving when dir=1), 11 hold
clr  input  1  synchronous clear of value and count
load  input  1  synchronous parallel load
load_data  input  WIDTH  parallel load value
value  output  WIDTH  live operand register
count  output  $clog2(WIDTH+1)  bits entered since last clear/load, saturating
full  output  1  count == WIDTH
out_valid  output  1  committed operand available
out_ready  input  1  consumer accepts out_data
out_data  output  WIDTH  committed operand, stable while out_valid

Behaviour:
- Reset (async, active-high): value=0, count=0, full=0, out_valid=0, out_data=0, all button-history flops=0.
- Edge detect: each button has a history flop. Pulse = (history==0 && raw==1), combinational in the same cycle the raw input is first seen high. History updates every clock. A held button yields exactly one pulse.
- Step event = pulse0 | pulse1. Inserted bit d = pulse1: if both pulse in the same cycle, a single shift occurs with d=1.
- Update priority per cycle: clr > load > step event > hold.
  - clr: value=0, count=0.
  - load: value=load_data, count=WIDTH.
- Step event by mode:
  - 00 shift-in: dir=0 → value={value[WIDTH-2:0],d}; dir=1 → value={d,value[WIDTH-1:1]}. count+1, saturating at WIDTH.
  - 01 rotate: d ignored. dir=0 → {value[WIDTH-2:0],value[WIDTH-1]}; dir=1 → {value[0],value[WIDTH-1:1]}. count unchanged.
  - 10 arithmetic: dir=1 → {value[WIDTH-1],value[WIDTH-1:1]}; dir=0 → {value[WIDTH-2:0],1'b0}. d ignored, count unchanged.
  - 11 hold: no change.
- Latency: value and count update on the clock edge that samples the rising button level. full is combinational from count.
- Commit handshake, two states:
  - IDLE: commit pulse → out_data=value (the pre-update value of that cycle), out_valid=1, go to BUSY.
  - BUSY: out_data frozen. Commit pulses are ignored. out_valid && out_ready → out_valid=0, go to IDLE. If AUTO_CLEAR=1, value=0 and count=0 that same edge; this clear takes priority over load/step in that cycle.
  - A commit pulse in the same cycle as a handshake completion is ignored.
- out_ready while out_valid=0 has no effect.
- Reset mid-BUSY drops the pending operand.

Optional Feature:
SHIFT_ENTRY_LOCK_EN
- Defined: in mode 00, step events are ignored while full=1; value is frozen until clr, load or an auto-clear.
- Undefined: shifting continues past full, discarding the bit shifted out; count stays saturated at WIDTH.

Decomposition:
- Package shift_entry_pkg: typedef enum logic [1:0] mode_t {MODE_SHIFT, MODE_ROTATE, MODE_ARITH, MODE_HOLD}; typedef enum logic {ST_IDLE, ST_BUSY} hs_state_t.
- One sub-module, btn_edge: parametrised rising-edge detector taking hz100, reset and a raw level, producing a pulse. Instantiated three times.

Test Plan:
- WIDTH=8, mode 00, dir=0: press btn1, btn0, btn1, btn1 (one release between presses) → value=8'h0B, count=4, full=0. Holding btn1 for 10 cycles → exactly one shift.
- load_data=8'h81 with load=1, then mode 01 dir=0 with one btn0 press → value=8'h03; then dir=1 with one press → value=8'h81; count stays 8.
- load 8'hA0, mode 10 dir=1, two presses → value=8'hE8. Then dir=0, one press → 8'hD0.
- value=8'h5A: commit pulse with out_ready=0 → out_valid=1, out_data=8'h5A. Shift in a 1 (dir=0) → value=8'hB5, out_data still 8'h5A. A second commit is ignored. Raise out_ready for 1 cycle → out_valid=0 and, with AUTO_CLEAR=1, value=0, count=0.
- Enter 9 bits of 1 in mode 00 → count=8, full=1. Without SHIFT_ENTRY_LOCK_EN, value=8'hFF. With it defined, after 8'hFF the 9th btn0 press leaves value=8'hFF.
- Assert reset asynchronously mid-BUSY → value, count, out_valid and out_data all read 0 immediately, with no clock edge. Same-cycle clr and load → value=0.

Source files
------------

// File: rtl/shift_entry_pkg.sv
// shift_entry_pkg: shared mode and handshake-state types for the operand entry register.
package shift_entry_pkg;
   typedef enum logic [1:0] {MODE_SHIFT, MODE_ROTATE, MODE_ARITH, MODE_HOLD} mode_t;
   typedef enum logic {ST_IDLE, ST_BUSY} hs_state_t;
endpackage

// File: rtl/shift_entry_reg_btn_edge.sv
// btn_edge: rising-edge detector for raw button levels; one pulse per press, same cycle as the rise.
module btn_edge #(
   parameter int W = 1
) (
   input  logic         hz100,
   input  logic         reset,
   input  logic [W-1:0] raw,
   output logic [W-1:0] pulse
);
   logic [W-1:0] hist_q;
   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) hist_q <= '0;
      else hist_q <= raw;
   end
   assign pulse = raw & ~hist_q;
endmodule

// File: rtl/shift_entry_reg.sv
// shift_entry_reg: button-driven operand entry with shift/rotate/arith/load and valid/ready commit.
// Optional SHIFT_ENTRY_LOCK_EN freezes shift-in entry once the operand is full.
module shift_entry_reg
   import shift_entry_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter bit AUTO_CLEAR = 1'b1
) (
   input  logic                       hz100,
   input  logic                       reset,
   input  logic                       btn0,
   input  logic                       btn1,
   input  logic                       btn_commit,
   input  logic                       dir,
   input  logic [1:0]                 mode,
   input  logic                       clr,
   input  logic                       load,
   input  logic [WIDTH-1:0]           load_data,
   output logic [WIDTH-1:0]           value,
   output logic [$clog2(WIDTH+1)-1:0] count,
   output logic                       full,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data
);
   localparam int CW = $clog2(WIDTH+1);
   localparam logic [CW-1:0] CMAX = CW'(WIDTH);
   mode_t            mode_e;
   hs_state_t        state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d, out_data_q, out_data_d, shifted;
   logic [CW-1:0]    count_q, count_d;
   logic             p0, p1, pc, step, hs_done, wipe, lock;
   btn_edge u_b0 (.hz100(hz100), .reset(reset), .raw(btn0),       .pulse(p0));
   btn_edge u_b1 (.hz100(hz100), .reset(reset), .raw(btn1),       .pulse(p1));
   btn_edge u_bc (.hz100(hz100), .reset(reset), .raw(btn_commit), .pulse(pc));
   assign mode_e  = mode_t'(mode);
   assign step    = p0 | p1;
   assign full    = count_q == CMAX;
   assign hs_done = (state_q == ST_BUSY) & out_ready;
   assign wipe    = AUTO_CLEAR & hs_done;
`ifdef SHIFT_ENTRY_LOCK_EN
   assign lock = full & (mode_e == MODE_SHIFT);
`else
   assign lock = 1'b0;
`endif
   // p1 doubles as the inserted bit, so a simultaneous press of both buttons enters a 1
   always_comb begin
      case (mode_e)
         MODE_SHIFT:  shifted = dir ? {p1, value_q[WIDTH-1:1]} : {value_q[WIDTH-2:0], p1};
         MODE_ROTATE: shifted = dir ? {value_q[0], value_q[WIDTH-1:1]} : {value_q[WIDTH-2:0], value_q[WIDTH-1]};
         MODE_ARITH:  shifted = dir ? {value_q[WIDTH-1], value_q[WIDTH-1:1]} : {value_q[WIDTH-2:0], 1'b0};
         default:     shifted = value_q;
      endcase
   end
   always_comb begin
      value_d = value_q;
      count_d = count_q;
      if (clr || wipe) begin
         value_d = '0;
         count_d = '0;
      end else if (load) begin
         value_d = load_data;
         count_d = CMAX;
      end else if (step && !lock) begin
         value_d = shifted;
         count_d = (mode_e == MODE_SHIFT && !full) ? count_q + CW'(1) : count_q;
      end
   end
   always_ff @(posedge hz100 or posedge reset) begin
      if (reset) begin
         value_q    <= '0;
         count_q    <= '0;
         out_data_q <= '0;
         state_q    <= ST_IDLE;
      end else begin
         value_q    <= value_d;
         count_q    <= count_d;
         out_data_q <= out_data_d;
         state_q    <= state_d;
      end
   end
   // commit captures the pre-update value; commits while BUSY are dropped
   always_comb begin
      state_d    = (state_q == ST_IDLE) ? (pc ? ST_BUSY : ST_IDLE) : (out_ready ? ST_IDLE : ST_BUSY);
      out_data_d = (state_q == ST_IDLE && pc) ? value_q : out_data_q;
   end
   always_comb begin
      out_valid = state_q == ST_BUSY;
      value     = value_q;
      count     = count_q;
      out_data  = out_data_q;
   end
endmodule

// File: tb/tb_shift_entry_reg.sv
// tb_shift_entry_reg: scoreboard bench for shift_entry_reg (WIDTH=8, AUTO_CLEAR=1).
module tb_shift_entry_reg;
   logic       hz100 = 1'b0, reset, btn0, btn1, btn_commit, dir, clr, load, out_ready;
   logic [1:0] mode;
   logic [7:0] load_data, value, out_data;
   logic [3:0] count;
   logic       full, out_valid;
   int         n_checks = 0, n_errors = 0;
   typedef struct {logic [7:0] v; int c;} exp_t;
   exp_t       exp_q[$];
   logic [7:0] out_q[$];
   logic [7:0] mval = 8'h00;
   int         mcnt = 0;
   bit         mbusy = 1'b0;

   shift_entry_reg #(.WIDTH(8), .AUTO_CLEAR(1'b1)) dut (
      .hz100(hz100), .reset(reset), .btn0(btn0), .btn1(btn1), .btn_commit(btn_commit),
      .dir(dir), .mode(mode), .clr(clr), .load(load), .load_data(load_data),
      .value(value), .count(count), .full(full), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data)
   );

   always #5 hz100 = ~hz100;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge hz100);
      #1;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_value"}, value, mval);
      check({tag, "_count"}, count, mcnt);
      check({tag, "_full"}, full, mcnt == 8);
   endtask

   task automatic model_step(input logic d);
      bit locked;
      locked = 1'b0;
`ifdef SHIFT_ENTRY_LOCK_EN
      locked = mcnt == 8;
`endif
      case (mode)
         2'b00: if (!locked) begin
            mval = dir ? {d, mval[7:1]} : {mval[6:0], d};
            if (mcnt < 8) mcnt++;
         end
         2'b01: mval = dir ? {mval[0], mval[7:1]} : {mval[6:0], mval[7]};
         2'b10: mval = dir ? {mval[7], mval[7:1]} : {mval[6:0], 1'b0};
         default: ;
      endcase
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         check({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_value"}, value, e.v);
         check({tag, "_count"}, count, e.c);
      end
   endtask

   task automatic press(input bit b, input string tag);
      if (b) btn1 = 1'b1;
      else btn0 = 1'b1;
      model_step(b);
      exp_q.push_back('{mval, mcnt});
      tick();
      pop_check(tag);
      btn0 = 1'b0;
      btn1 = 1'b0;
      tick();
   endtask

   task automatic do_load(input logic [7:0] d);
      load = 1'b1;
      load_data = d;
      mval = d;
      mcnt = 8;
      tick();
      load = 1'b0;
   endtask

   task automatic commit(input string tag);
      btn_commit = 1'b1;
      if (!mbusy) begin
         out_q.push_back(mval);
         mbusy = 1'b1;
      end
      tick();
      check({tag, "_valid"}, out_valid, mbusy);
      if (out_q.size() != 0) check({tag, "_data"}, out_data, out_q[0]);
      btn_commit = 1'b0;
      tick();
   endtask

   task automatic handshake(input string tag);
      out_ready = 1'b1;
      if (mbusy) check({tag, "_data"}, out_data, out_q.pop_front());
      tick();
      out_ready = 1'b0;
      if (mbusy) begin
         mbusy = 1'b0;
         mval = 8'h00;
         mcnt = 0;
      end
      check({tag, "_valid"}, out_valid, 0);
      check_state(tag);
   endtask

   initial begin
      reset = 1'b1; btn0 = 1'b0; btn1 = 1'b0; btn_commit = 1'b0; dir = 1'b0; mode = 2'b00;
      clr = 1'b0; load = 1'b0; load_data = 8'h00; out_ready = 1'b0;
      #12;
      check_state("reset");
      check("reset_valid", out_valid, 0);
      check("reset_data", out_data, 0);
      reset = 1'b0;
      tick();
      // shift-in toward MSB
      press(1'b1, "s1"); press(1'b0, "s2"); press(1'b1, "s3"); press(1'b1, "s4");
      check("shift_0b", value, 8'h0B);
      check_state("shift4");
      // held button: exactly one shift
      btn1 = 1'b1;
      model_step(1'b1);
      exp_q.push_back('{mval, mcnt});
      tick();
      pop_check("hold_first");
      repeat (9) tick();
      check_state("hold10");
      btn1 = 1'b0;
      tick();
      // rotate
      do_load(8'h81);
      check_state("load81");
      mode = 2'b01;
      press(1'b0, "rotl");
      check("rotl_03", value, 8'h03);
      dir = 1'b1;
      press(1'b0, "rotr");
      check("rotr_81", value, 8'h81);
      // arithmetic
      do_load(8'hA0);
      mode = 2'b10;
      press(1'b0, "asr1"); press(1'b1, "asr2");
      check("asr_e8", value, 8'hE8);
      dir = 1'b0;
      press(1'b0, "asl");
      check("asl_d0", value, 8'hD0);
      // hold mode
      mode = 2'b11;
      press(1'b1, "modehold");
      // commit handshake
      mode = 2'b00;
      do_load(8'h5A);
      commit("commit1");
      press(1'b1, "busy_shift");
      check("busy_b5", value, 8'hB5);
      check("busy_frozen", out_data, 8'h5A);
      commit("commit2_ignored");
      handshake("hs");
      // fill past full
      clr = 1'b1; tick(); clr = 1'b0;
      for (int i = 0; i < 8; i++) press(1'b1, "fill");
      check_state("full8");
      press(1'b0, "fill9");
      // async reset mid-BUSY
      commit("commit3");
      press(1'b1, "pre_reset");
      #2;
      reset = 1'b1;
      #1;
      mval = 8'h00; mcnt = 0; mbusy = 1'b0;
      out_q.delete();
      exp_q.delete();
      check_state("areset");
      check("areset_valid", out_valid, 0);
      check("areset_data", out_data, 0);
      #1;
      reset = 1'b0;
      tick();
      // clr beats load
      do_load(8'h3C);
      clr = 1'b1; load = 1'b1; load_data = 8'hC3;
      mval = 8'h00; mcnt = 0;
      tick();
      clr = 1'b0; load = 1'b0;
      check_state("clr_load");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
